// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit pair per clock, LSB first, result latched at completion.
// Optional overflow flag enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             V
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    maj3 = (x & y) | (x & z) | (y & z);
  endfunction

  state_t           state_r;
  state_t           state_s;
  // acc_r shifts operand A out of the LSB while sum bits enter at the MSB
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             done_r;
  logic             sum_bit_s;
  logic             carry_nxt_s;
  logic             last_s;

  assign sum_bit_s   = acc_r[0] ^ b_r[0] ^ carry_r;
  assign carry_nxt_s = maj3(acc_r[0], b_r[0], carry_r);
  assign last_s      = (cnt_r == LAST_CNT);

  // Next-state logic for the IDLE/RUN controller
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = IDLE;
        end else begin
          state_s = RUN;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, serial datapath and result latching
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1: invert B and seed the carry with C
            acc_r   <= A;
            b_r     <= B ^ {WIDTH{C}};
            carry_r <= C;
            cnt_r   <= {CNT_W{1'b0}};
          end
        end
        RUN: begin
          acc_r   <= {sum_bit_s, acc_r[WIDTH-1:1]};
          b_r     <= {1'b0, b_r[WIDTH-1:1]};
          carry_r <= carry_nxt_s;
          cnt_r   <= cnt_r + CNT_W'(1);
          if (last_s) begin
            s_r    <= {sum_bit_s, acc_r[WIDTH-1:1]};
            cout_r <= carry_nxt_s;
            done_r <= 1'b1;
          end
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef SERIAL_ADDSUB_OVF_EN
  logic v_r;

  // Overflow: on the final edge carry_r is the carry into the MSB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_r <= 1'b0;
    end else if ((state_r == RUN) && last_s) begin
      v_r <= carry_r ^ carry_nxt_s;
    end else begin
      v_r <= v_r;
    end
  end

  assign V = v_r;
`else
  assign V = 1'b0;
`endif

  assign busy = (state_r == RUN);
  assign done = done_r;
  assign S    = s_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH=4): stimulus pushes expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_addsub;

  localparam int W = 4;
`ifdef SERIAL_ADDSUB_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         C = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] S;
  logic         Cout;
  logic         V;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .C(C),
    .busy(busy), .done(done), .S(S), .Cout(Cout), .V(V)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] s;
    logic         co;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   busy_run = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks = checks + 1;
    if (act != exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: compare each done pulse against the oldest expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run = 0;
    end else if (busy) begin
      busy_run = busy_run + 1;
    end else begin
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("S", int'(S), int'(e.s));
          check("Cout", int'(Cout), int'(e.co));
          check("V", int'(V), int'(e.v));
          check("done_latency", cyc, e.cyc);
          check("busy_cycles", busy_run, W);
        end
      end
      busy_run = 0;
    end
  end

  // Called at a negedge: drive an operation, keep start high for hold cycles
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic eco, input logic ev,
                       input int hold);
    exp_t e;
    A = a; B = b; C = c; start = 1'b1;
    e.s = es; e.co = eco; e.v = ev & OVF; e.cyc = cyc + 1 + W;
    q.push_back(e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      A = ~A; B = B + 4'd5; C = ~C;
    end
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n = n + 1;
    end
    if (!done) check("done_timeout", 0, 1);
  endtask

  initial begin
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_S", int'(S), 0);
    check("rst_Cout", int'(Cout), 0);
    check("rst_V", int'(V), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    issue(4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1, 1);  wait_done(); @(negedge clk);
    issue(4'd7, 4'd2, 1'b1, 4'd5, 1'b1, 1'b0, 1);  wait_done(); @(negedge clk);
    issue(4'd0, 4'd1, 1'b1, 4'd15, 1'b0, 1'b0, 1); wait_done(); @(negedge clk);
    issue(4'd6, 4'd6, 1'b0, 4'd12, 1'b0, 1'b1, 1); wait_done(); @(negedge clk);
    issue(4'd9, 4'd3, 1'b1, 4'd6, 1'b1, 1'b1, 1);  wait_done(); @(negedge clk);
    issue(4'd4, 4'd6, 1'b1, 4'd14, 1'b0, 1'b0, 1); wait_done(); @(negedge clk);
    // start held and operands scrambled through RUN, then back-to-back
    issue(4'd8, 4'd1, 1'b1, 4'd7, 1'b1, 1'b1, W);  wait_done();
    issue(4'd3, 4'd4, 1'b0, 4'd7, 1'b0, 1'b0, 1);  wait_done(); @(negedge clk);

    // Abort mid-RUN: outputs clear immediately and no done follows
    issue(4'd5, 4'd3, 1'b0, 4'd8, 1'b0, 1'b1, 1);
    @(negedge clk);
    rst_n = 1'b0;
    void'(q.pop_back());
    #1;
    check("abort_S", int'(S), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_Cout", int'(Cout), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // start present at the first edge after reset release
    issue(4'd15, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0, 1); wait_done(); @(negedge clk);

    for (int i = 0; i < 8; i++) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
